// File: rtl/counter_mod_updown_pkg.sv
// Shared constants for the modulo up/down counter family.
package counter_mod_updown_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_MODULUS = 16;

endpackage

// File: rtl/counter_mod_updown_if.sv
// Control/status bundle of one counter stage; master drives controls, slave (counter) drives status.
interface counter_mod_updown_if
  import counter_mod_updown_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, d,
    input  q, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, d,
    output q, tc, wrap
  );

endinterface

// File: rtl/counter_mod_updown_next_state.sv
// Combinational next-count, wrap-flag and terminal-count logic for one counter stage.
module counter_mod_updown_next_state
  import counter_mod_updown_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MODULUS  = DEF_MODULUS,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_q_next_c,
  output logic             o_wrap_next_c,
  output logic             o_tc_c
);

  // Top of range; MODULUS may be 2^WIDTH so the load compare needs one extra bit.
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic w_at_max;
  logic w_at_min;
  logic w_d_over;

  assign w_at_max = (i_q == MAX_Q);
  assign w_at_min = (i_q == '0);
  assign w_d_over = ({1'b0, i_d} >= MOD_EXT);

  // Terminal count: this enabled edge would cross the boundary in the current direction.
  assign o_tc_c = i_en & (((i_up_dn == DIR_UP) & w_at_max) | ((i_up_dn == DIR_DN) & w_at_min));

  // Priority load > count > hold; explicit boundary compares even for power-of-two moduli.
  always_comb begin
    o_q_next_c    = i_q;
    o_wrap_next_c = 1'b0;
    if (i_load) begin
      o_q_next_c = w_d_over ? MAX_Q : i_d;
    end else if (i_en) begin
      if (i_up_dn == DIR_UP) begin
        if (!w_at_max) begin
          o_q_next_c = i_q + WIDTH'(1);
        end else if (SATURATE != MODE_SAT) begin
          o_q_next_c    = '0;
          o_wrap_next_c = 1'b1;
        end
      end else begin
        if (!w_at_min) begin
          o_q_next_c = i_q - WIDTH'(1);
        end else if (SATURATE != MODE_SAT) begin
          o_q_next_c    = MAX_Q;
          o_wrap_next_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/counter_mod_updown.sv
// Modulo-N up/down counter stage: count/wrap registers around the next-state block.
module counter_mod_updown
  import counter_mod_updown_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MODULUS  = DEF_MODULUS,
  parameter int unsigned SATURATE = MODE_WRAP,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_mod_updown_if.slave  bus
);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_tc;

  counter_mod_updown_next_state #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .i_en          (bus.en),
    .i_up_dn       (bus.up_dn),
    .i_load        (bus.load),
    .i_d           (bus.d),
    .i_q           (r_q),
    .o_q_next_c    (w_q_next),
    .o_wrap_next_c (w_wrap_next),
    .o_tc_c        (w_tc)
  );

  // Count and wrap-pulse registers; reset overrides any load/step and clears a pending wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= WIDTH'(RST_VAL);
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.q    = r_q;
  assign bus.wrap = r_wrap;
  assign bus.tc   = w_tc;

endmodule
